// File: rtl/eth_lite_pkg.sv
// Shared EthernetLite definitions: buffer addresses, control-frame constants,
// and the state encodings used by the RX config poller and its bus engine.
package eth_lite_pkg;

    localparam logic [12:0] TX_PING_BASE = 13'h0000;
    localparam logic [12:0] TX_PING_LEN  = 13'h07F4;
    localparam logic [12:0] TX_PING_CTRL = 13'h07FC;
    localparam logic [12:0] RX_PING_BASE = 13'h1000;
    localparam logic [12:0] RX_PING_CTRL = 13'h17FC;

    localparam logic [15:0] ETH_TYPE_CTRL = 16'h88B5;
    localparam logic [7:0]  CMD_SET_CFG   = 8'h01;
    localparam logic [47:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_RD_STAT,
        RX_RD_W0,
        RX_RD_W1,
        RX_RD_W3,
        RX_RD_W4,
        RX_CHECK,
        RX_CLR
    } rx_state_t;

    typedef enum logic [2:0] {
        AXL_IDLE,
        AXL_AR,
        AXL_R,
        AXL_W,
        AXL_B
    } axil_state_t;

    // The MAC buffer stores frame byte n in lane n%4 of word n/4.
    function automatic logic [7:0] buf_byte(input logic [31:0] word, input logic [1:0] lane);
        return word[{lane, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/axil_single_master.sv
// One-outstanding AXI4-Lite read/write engine: a start pulse launches a single
// transfer, done pulses for one cycle when its response has been taken.
module axil_single_master
    import eth_lite_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic        write,
    input  logic [12:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic [12:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [12:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    axil_state_t state_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg     <= AXL_IDLE;
            done          <= 1'b0;
            rdata         <= '0;
            err           <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                AXL_IDLE: begin
                    if (start) begin
                        if (write) begin
                            m_axi_awaddr  <= addr;
                            m_axi_wdata   <= wdata;
                            m_axi_wstrb   <= 4'hF;
                            m_axi_awvalid <= 1'b1;
                            m_axi_wvalid  <= 1'b1;
                            state_reg     <= AXL_W;
                        end else begin
                            m_axi_araddr  <= addr;
                            m_axi_arvalid <= 1'b1;
                            state_reg     <= AXL_AR;
                        end
                    end
                end
                AXL_AR: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state_reg     <= AXL_R;
                    end
                end
                AXL_R: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        rdata        <= m_axi_rdata;
                        err          <= |m_axi_rresp;
                        done         <= 1'b1;
                        state_reg    <= AXL_IDLE;
                    end
                end
                AXL_W: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    // Address and data channels retire independently; B opens once both have.
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state_reg    <= AXL_B;
                    end
                end
                AXL_B: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        err          <= |m_axi_bresp;
                        done         <= 1'b1;
                        state_reg    <= AXL_IDLE;
                    end
                end
                default: state_reg <= AXL_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/eth_rx_config.sv
// Polls the EthernetLite RX ping buffer, validates control frames and applies
// the two stick phase-increment words they carry.
module eth_rx_config
    import eth_lite_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = ETH_TYPE_CTRL,
    parameter logic [12:0] CFG_1_INIT  = 13'h0EB8,
    parameter logic [12:0] CFG_2_INIT  = 13'h0D71,
    parameter int          POLL_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    output logic [12:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [12:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic [12:0] cfg_1_data,
    output logic [12:0] cfg_2_data,
    output logic        cfg_valid,
    output logic [15:0] rx_good_count,
    output logic [15:0] rx_drop_count
);

    localparam int PCW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_CYCLES - 1);

    rx_state_t      state_reg;
    logic [PCW-1:0] poll_cnt_reg;
    logic           start_reg;
    logic           write_reg;
    logic [12:0]    addr_reg;
    logic [47:0]    dest_reg;
    logic [15:0]    etype_reg;
    logic [7:0]     cmd_reg;
    logic [15:0]    cfg1_reg;
    logic [15:0]    cfg2_reg;
    logic           rd_err_reg;

    logic           eng_done;
    logic           eng_err;
    logic [31:0]    eng_rdata;
    logic           accept;

    axil_single_master u_master (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .start         (start_reg),
        .write         (write_reg),
        .addr          (addr_reg),
        .wdata         (32'h0),
        .done          (eng_done),
        .rdata         (eng_rdata),
        .err           (eng_err),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    assign accept = ((dest_reg == LOCAL_MAC) || (dest_reg == BROADCAST_MAC))
                 && (etype_reg == ETHERTYPE)
                 && (cmd_reg == CMD_SET_CFG)
                 && (cfg1_reg[15:13] == 3'b000)
                 && (cfg2_reg[15:13] == 3'b000)
                 && !rd_err_reg;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_reg     <= RX_IDLE;
            poll_cnt_reg  <= '0;
            start_reg     <= 1'b0;
            write_reg     <= 1'b0;
            addr_reg      <= '0;
            dest_reg      <= '0;
            etype_reg     <= '0;
            cmd_reg       <= '0;
            cfg1_reg      <= '0;
            cfg2_reg      <= '0;
            rd_err_reg    <= 1'b0;
            cfg_1_data    <= CFG_1_INIT;
            cfg_2_data    <= CFG_2_INIT;
            cfg_valid     <= 1'b0;
            rx_good_count <= '0;
            rx_drop_count <= '0;
        end else begin
            start_reg <= 1'b0;
            cfg_valid <= 1'b0;
            case (state_reg)
                RX_IDLE: begin
                    if (poll_cnt_reg == POLL_LAST) begin
                        state_reg <= RX_RD_STAT;
                        start_reg <= 1'b1;
                        write_reg <= 1'b0;
                        addr_reg  <= RX_PING_CTRL;
                    end else begin
                        poll_cnt_reg <= poll_cnt_reg + 1'b1;
                    end
                end
                RX_RD_STAT: begin
                    if (eng_done) begin
                        if (eng_err || !eng_rdata[0]) begin
                            state_reg    <= RX_IDLE;
                            poll_cnt_reg <= '0;
                        end else begin
                            state_reg  <= RX_RD_W0;
                            start_reg  <= 1'b1;
                            addr_reg   <= RX_PING_BASE;
                            rd_err_reg <= 1'b0;
                        end
                    end
                end
                RX_RD_W0: begin
                    if (eng_done) begin
                        dest_reg[47:16] <= {buf_byte(eng_rdata, 2'd0), buf_byte(eng_rdata, 2'd1),
                                            buf_byte(eng_rdata, 2'd2), buf_byte(eng_rdata, 2'd3)};
                        rd_err_reg <= rd_err_reg | eng_err;
                        state_reg  <= RX_RD_W1;
                        start_reg  <= 1'b1;
                        addr_reg   <= RX_PING_BASE + 13'h004;
                    end
                end
                RX_RD_W1: begin
                    if (eng_done) begin
                        dest_reg[15:0] <= {buf_byte(eng_rdata, 2'd0), buf_byte(eng_rdata, 2'd1)};
                        rd_err_reg <= rd_err_reg | eng_err;
                        // Word 2 holds only the source MAC, so it is skipped.
                        state_reg  <= RX_RD_W3;
                        start_reg  <= 1'b1;
                        addr_reg   <= RX_PING_BASE + 13'h00C;
                    end
                end
                RX_RD_W3: begin
                    if (eng_done) begin
                        etype_reg  <= {buf_byte(eng_rdata, 2'd0), buf_byte(eng_rdata, 2'd1)};
                        cmd_reg    <= buf_byte(eng_rdata, 2'd2);
                        rd_err_reg <= rd_err_reg | eng_err;
                        state_reg  <= RX_RD_W4;
                        start_reg  <= 1'b1;
                        addr_reg   <= RX_PING_BASE + 13'h010;
                    end
                end
                RX_RD_W4: begin
                    if (eng_done) begin
                        cfg1_reg   <= {buf_byte(eng_rdata, 2'd0), buf_byte(eng_rdata, 2'd1)};
                        cfg2_reg   <= {buf_byte(eng_rdata, 2'd2), buf_byte(eng_rdata, 2'd3)};
                        rd_err_reg <= rd_err_reg | eng_err;
                        state_reg  <= RX_CHECK;
                    end
                end
                RX_CHECK: begin
                    if (accept) begin
                        cfg_1_data <= cfg1_reg[12:0];
                        cfg_2_data <= cfg2_reg[12:0];
                        cfg_valid  <= 1'b1;
                        if (rx_good_count != 16'hFFFF) rx_good_count <= rx_good_count + 16'd1;
                    end else begin
                        if (rx_drop_count != 16'hFFFF) rx_drop_count <= rx_drop_count + 16'd1;
                    end
                    state_reg <= RX_CLR;
                    start_reg <= 1'b1;
                    write_reg <= 1'b1;
                    addr_reg  <= RX_PING_CTRL;
                end
                RX_CLR: begin
                    // Write response code is deliberately ignored: the buffer is released either way.
                    if (eng_done) begin
                        state_reg    <= RX_IDLE;
                        poll_cnt_reg <= '0;
                        write_reg    <= 1'b0;
                    end
                end
                default: begin
                    state_reg    <= RX_IDLE;
                    poll_cnt_reg <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_config.sv
// Directed bench for eth_rx_config: a small EthernetLite RX-buffer slave model
// with programmable ready stalls, plus hand-computed frame expectations.
module tb_eth_rx_config;

    localparam int P = 16;
    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam int CTRL_IDX = 'h17FC >> 2;
    localparam int BASE_IDX = 'h1000 >> 2;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [12:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic [12:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready = 1'b0;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready = 1'b0;
    logic [1:0]  m_axi_bresp = '0;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [12:0] cfg_1_data;
    logic [12:0] cfg_2_data;
    logic        cfg_valid;
    logic [15:0] rx_good_count;
    logic [15:0] rx_drop_count;

    always #5 aclk = ~aclk;

    eth_rx_config #(
        .LOCAL_MAC   (MY_MAC),
        .ETHERTYPE   (16'h88B5),
        .CFG_1_INIT  (13'h0EB8),
        .CFG_2_INIT  (13'h0D71),
        .POLL_CYCLES (P)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .cfg_1_data    (cfg_1_data),
        .cfg_2_data    (cfg_2_data),
        .cfg_valid     (cfg_valid),
        .rx_good_count (rx_good_count),
        .rx_drop_count (rx_drop_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Slave model state
    logic [31:0] mem [0:2047];
    int          cycle = 0;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [12:0] cur_raddr, cur_waddr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_wstrb;
    logic [12:0] rd_addr_q [$];
    int          rd_cyc_q [$];
    logic [12:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [3:0]  wr_strb_q [$];
    int          w4_cyc = 0;
    int          valid_cnt = 0;
    int          valid_cyc = 0;
    int          proto_err = 0;
    int          bready_err = 0;
    int          ar_stall = 0, aw_stall = 0, w_stall = 0;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;
    bit          aw_done = 0, w_done = 0;
    bit          prev_arv = 0, prev_arr = 0, prev_awv = 0, prev_awr = 0, prev_wv = 0, prev_wr = 0;
    logic [12:0] prev_araddr = '0, prev_awaddr = '0;

    // Edge sampler: observes handshakes and valid stability at the active edge.
    always @(posedge aclk) begin
        cycle++;
        ar_hs = aresetn && m_axi_arvalid && m_axi_arready;
        r_hs  = aresetn && m_axi_rvalid && m_axi_rready;
        aw_hs = aresetn && m_axi_awvalid && m_axi_awready;
        w_hs  = aresetn && m_axi_wvalid && m_axi_wready;
        b_hs  = aresetn && m_axi_bvalid && m_axi_bready;
        if (ar_hs) begin
            cur_raddr = m_axi_araddr;
            rd_addr_q.push_back(m_axi_araddr);
            rd_cyc_q.push_back(cycle);
        end
        if (r_hs) begin
            $display("rd addr=%h data=%h cycle=%0d", cur_raddr, m_axi_rdata, cycle);
            if (cur_raddr == 13'h1010) w4_cyc = cycle;
        end
        if (aw_hs) cur_waddr = m_axi_awaddr;
        if (w_hs) begin
            cur_wdata = m_axi_wdata;
            cur_wstrb = m_axi_wstrb;
        end
        if (!aresetn) begin
            prev_arv = 0; prev_arr = 0; prev_awv = 0; prev_awr = 0; prev_wv = 0; prev_wr = 0;
        end else begin
            if (prev_arv && !prev_arr && (!m_axi_arvalid || m_axi_araddr != prev_araddr)) proto_err++;
            if (prev_awv && !prev_awr && (!m_axi_awvalid || m_axi_awaddr != prev_awaddr)) proto_err++;
            if (prev_wv && !prev_wr && !m_axi_wvalid) proto_err++;
            prev_arv = m_axi_arvalid; prev_arr = m_axi_arready; prev_araddr = m_axi_araddr;
            prev_awv = m_axi_awvalid; prev_awr = m_axi_awready; prev_awaddr = m_axi_awaddr;
            prev_wv  = m_axi_wvalid;  prev_wr  = m_axi_wready;
        end
    end

    // Slave responder: drives all bus inputs on the falling edge.
    always @(negedge aclk) begin
        if (cfg_valid) begin
            valid_cnt++;
            valid_cyc = cycle;
        end
        if (!aresetn) begin
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
            aw_done = 0; w_done = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
        end else begin
            if (r_hs) m_axi_rvalid = 0;
            if (ar_hs) begin
                m_axi_arready = 0;
                ar_cnt = 0;
                m_axi_rvalid = 1;
                m_axi_rdata = mem[cur_raddr[12:2]];
                m_axi_rresp = 2'b00;
            end else if (m_axi_arvalid && !m_axi_arready) begin
                if (ar_cnt >= ar_stall) m_axi_arready = 1;
                else ar_cnt++;
            end
            if (b_hs) begin
                m_axi_bvalid = 0; aw_done = 0; w_done = 0;
            end
            if (aw_hs) begin
                m_axi_awready = 0; aw_done = 1; aw_cnt = 0;
            end else if (m_axi_awvalid && !m_axi_awready && !aw_done) begin
                if (aw_cnt >= aw_stall) m_axi_awready = 1;
                else aw_cnt++;
            end
            if (w_hs) begin
                m_axi_wready = 0; w_done = 1; w_cnt = 0;
            end else if (m_axi_wvalid && !m_axi_wready && !w_done) begin
                if (w_cnt >= w_stall) m_axi_wready = 1;
                else w_cnt++;
            end
            if (aw_done && w_done && !m_axi_bvalid) begin
                mem[cur_waddr[12:2]] = cur_wdata;
                wr_addr_q.push_back(cur_waddr);
                wr_data_q.push_back(cur_wdata);
                wr_strb_q.push_back(cur_wstrb);
                $display("wr addr=%h data=%h strb=%h cycle=%0d", cur_waddr, cur_wdata, cur_wstrb, cycle);
                m_axi_bvalid = 1;
                m_axi_bresp = 2'b00;
            end
            if (m_axi_bready && !(aw_done && w_done)) bready_err++;
        end
    end

    task automatic clear_logs();
        rd_addr_q.delete(); rd_cyc_q.delete();
        wr_addr_q.delete(); wr_data_q.delete(); wr_strb_q.delete();
        valid_cnt = 0;
    endtask

    task automatic load_frame(input logic [47:0] dest, input logic [15:0] etype, input logic [7:0] cmd,
                              input logic [15:0] c1, input logic [15:0] c2);
        logic [7:0] b [0:19];
        for (int i = 0; i < 6; i++) b[i] = dest[8*(5-i) +: 8];
        for (int i = 6; i < 12; i++) b[i] = 8'hA0 + 8'(i);
        b[12] = etype[15:8]; b[13] = etype[7:0]; b[14] = cmd; b[15] = 8'h5A;
        b[16] = c1[15:8]; b[17] = c1[7:0]; b[18] = c2[15:8]; b[19] = c2[7:0];
        for (int w = 0; w < 5; w++) mem[BASE_IDX + w] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
        clear_logs();
        mem[CTRL_IDX] = 32'h1;
    endtask

    task automatic wait_clear(input string tag, input int budget);
        int n = 0;
        while (mem[CTRL_IDX][0] !== 1'b0 && n < budget) begin
            @(negedge aclk);
            n++;
        end
        check_eq(tag, 64'(mem[CTRL_IDX][0]), 64'd0);
        repeat (6) @(negedge aclk);
    endtask

    task automatic check_last_write(input string tag);
        int sz = wr_addr_q.size();
        check_eq({tag, "_wr_count"}, 64'(sz), 64'd1);
        if (sz >= 1) begin
            check_eq({tag, "_wr_addr"}, 64'(wr_addr_q[sz-1]), 64'h17FC);
            check_eq({tag, "_wr_data"}, 64'(wr_data_q[sz-1]), 64'h0);
            check_eq({tag, "_wr_strb"}, 64'(wr_strb_q[sz-1]), 64'hF);
        end
    endtask

    initial begin
        logic [12:0] exp_seq [5];
        int sz;
        int n;
        int rel_cyc;
        exp_seq = '{13'h17FC, 13'h1000, 13'h1004, 13'h100C, 13'h1010};
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;

        // Reset state
        aresetn = 0;
        repeat (3) @(negedge aclk);
        check_eq("rst_arvalid", 64'(m_axi_arvalid), 0);
        check_eq("rst_rready", 64'(m_axi_rready), 0);
        check_eq("rst_awvalid", 64'(m_axi_awvalid), 0);
        check_eq("rst_wvalid", 64'(m_axi_wvalid), 0);
        check_eq("rst_bready", 64'(m_axi_bready), 0);
        check_eq("rst_addrs", 64'({m_axi_araddr, m_axi_awaddr}), 0);
        check_eq("rst_wdata_wstrb", 64'({m_axi_wdata, m_axi_wstrb}), 0);
        check_eq("rst_cfg1", 64'(cfg_1_data), 64'h0EB8);
        check_eq("rst_cfg2", 64'(cfg_2_data), 64'h0D71);
        check_eq("rst_cfg_valid", 64'(cfg_valid), 0);
        check_eq("rst_counts", 64'({rx_good_count, rx_drop_count}), 0);

        // Idle polling with an empty buffer
        aresetn = 1;
        clear_logs();
        repeat (3 * (P + 4) + 8) @(negedge aclk);
        sz = rd_addr_q.size();
        check_eq("idle_reads_ge3", 64'(sz >= 3), 1);
        n = 0;
        foreach (rd_addr_q[i]) if (rd_addr_q[i] != 13'h17FC) n++;
        check_eq("idle_other_addr", 64'(n), 0);
        if (sz >= 3) begin
            check_eq("idle_spacing_0", 64'(rd_cyc_q[1] - rd_cyc_q[0]), 64'(P + 4));
            check_eq("idle_spacing_1", 64'(rd_cyc_q[2] - rd_cyc_q[1]), 64'(P + 4));
        end
        check_eq("idle_no_writes", 64'(wr_addr_q.size()), 0);
        check_eq("idle_cfg", 64'({cfg_1_data, cfg_2_data}), 64'({13'h0EB8, 13'h0D71}));

        // Valid unicast frame
        load_frame(MY_MAC, 16'h88B5, 8'h01, 16'h0C00, 16'h0A00);
        wait_clear("valid_timeout", 300);
        sz = rd_addr_q.size();
        check_eq("valid_reads_ge5", 64'(sz >= 5), 1);
        if (sz >= 5)
            for (int k = 0; k < 5; k++)
                check_eq($sformatf("valid_seq%0d", k), 64'(rd_addr_q[sz-5+k]), 64'(exp_seq[k]));
        check_eq("valid_cfg1", 64'(cfg_1_data), 64'h0C00);
        check_eq("valid_cfg2", 64'(cfg_2_data), 64'h0A00);
        check_eq("valid_pulses", 64'(valid_cnt), 1);
        check_eq("valid_latency", 64'(valid_cyc - w4_cyc), 2);
        check_eq("valid_good", 64'(rx_good_count), 1);
        check_eq("valid_drop", 64'(rx_drop_count), 0);
        check_last_write("valid");

        // Broadcast destination but wrong EtherType
        load_frame(48'hFFFF_FFFF_FFFF, 16'h0800, 8'h01, 16'h0111, 16'h0222);
        wait_clear("etype_timeout", 300);
        check_eq("etype_cfg", 64'({cfg_1_data, cfg_2_data}), 64'({13'h0C00, 13'h0A00}));
        check_eq("etype_pulses", 64'(valid_cnt), 0);
        check_eq("etype_drop", 64'(rx_drop_count), 1);
        check_eq("etype_good", 64'(rx_good_count), 1);
        check_last_write("etype");

        // cfg1 with bits above the 13-bit field set
        load_frame(MY_MAC, 16'h88B5, 8'h01, 16'hE000, 16'h0100);
        wait_clear("range_timeout", 300);
        check_eq("range_cfg", 64'({cfg_1_data, cfg_2_data}), 64'({13'h0C00, 13'h0A00}));
        check_eq("range_pulses", 64'(valid_cnt), 0);
        check_eq("range_drop", 64'(rx_drop_count), 2);

        // Ready stalls: awready comes 5 cycles before wready
        ar_stall = 20; aw_stall = 20; w_stall = 25;
        proto_err = 0; bready_err = 0;
        load_frame(MY_MAC, 16'h88B5, 8'h01, 16'h0123, 16'h1ABC);
        wait_clear("stall_timeout", 1500);
        check_eq("stall_proto", 64'(proto_err), 0);
        check_eq("stall_bready_early", 64'(bready_err), 0);
        check_eq("stall_cfg", 64'({cfg_1_data, cfg_2_data}), 64'({13'h0123, 13'h1ABC}));
        check_eq("stall_good", 64'(rx_good_count), 2);
        check_eq("stall_pulses", 64'(valid_cnt), 1);
        check_last_write("stall");
        ar_stall = 0; aw_stall = 0; w_stall = 0;

        // Reset while waiting on the word-3 read
        load_frame(MY_MAC, 16'h88B5, 8'h01, 16'h0111, 16'h0222);
        n = 0;
        while (!(rd_addr_q.size() > 0 && rd_addr_q[rd_addr_q.size()-1] == 13'h100C) && n < 400) begin
            @(negedge aclk);
            n++;
        end
        check_eq("rst_mid_reached_w3", 64'(n < 400), 1);
        aresetn = 0;
        mem[CTRL_IDX] = 32'h0;
        @(negedge aclk);
        check_eq("rst_mid_valids", 64'({m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid, m_axi_bready}), 0);
        check_eq("rst_mid_cfg", 64'({cfg_1_data, cfg_2_data}), 64'({13'h0EB8, 13'h0D71}));
        check_eq("rst_mid_counts", 64'({rx_good_count, rx_drop_count}), 0);
        check_eq("rst_mid_cfg_valid", 64'(cfg_valid), 0);
        @(negedge aclk);
        aresetn = 1;
        rel_cyc = cycle;
        clear_logs();
        n = 0;
        while (rd_addr_q.size() == 0 && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check_eq("resume_read_seen", 64'(rd_addr_q.size() > 0), 1);
        if (rd_addr_q.size() > 0) begin
            check_eq("resume_addr", 64'(rd_addr_q[0]), 64'h17FC);
            check_eq("resume_delay", 64'(rd_cyc_q[0] - rel_cyc), 64'(P + 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_rx_config.md
Name: eth_rx_config

Overview:
- AXI4-Lite master that polls the EthernetLite MAC receive (ping) buffer, parses incoming control frames, and updates the two stick phase-generator config words at runtime.
- This is the receive-side counterpart of the transmit framer: the framer writes the TX buffer, this block reads the RX buffer.
- Shares the MAC slave port with the framer through a 2:1 AXI-Lite interconnect at top level.
- Runs in the axi_clk domain.

Parameters:
- LOCAL_MAC, 48'h02_00_00_00_00_01, unicast MAC accepted; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- ETHERTYPE, 16'h88B5, EtherType of control frames.
- CFG_1_INIT, 13'h0EB8, reset value of cfg_1_data.
- CFG_2_INIT, 13'h0D71, reset value of cfg_2_data.
- POLL_CYCLES, 1024, idle cycles between status polls (>=1).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- m_axi_araddr/arvalid/arready  out/out/in  13/1/1  AXI-Lite read address.
- m_axi_rdata/rresp/rvalid/rready  in/in/in/out  32/2/1/1  read data.
- m_axi_awaddr/awvalid/awready  out/out/in  13/1/1  write address.
- m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  32/4/1/1  write data.
- m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response.
- cfg_1_data  out  13  stick 1 phase increment.
- cfg_2_data  out  13  stick 2 phase increment.
- cfg_valid  out  1  one-cycle pulse when cfg_1_data/cfg_2_data change.
- rx_good_count  out  16  accepted frames, saturating.
- rx_drop_count  out  16  rejected frames, saturating.

Behaviour:
Reset (aresetn low at a clock edge):
- All valid/ready outputs 0; addresses and wdata 0; wstrb 0.
- cfg_1_data = CFG_1_INIT, cfg_2_data = CFG_2_INIT.
- cfg_valid 0; both counters 0.
- Poll counter 0; FSM to IDLE.
- Reset mid-transaction abandons it immediately; the MAC side is reset by the same aresetn.

Frame layout (EthernetLite buffer order: byte n at word n/4, bits [8*(n%4)+7 : 8*(n%4)]; network big-endian):
- Dest MAC: bytes 0-5.
- EtherType: bytes 12-13.
- Command: byte 14 (0x01 = set config).
- Byte 15: reserved.
- cfg1: bytes 16-17.
- cfg2: bytes 18-19.

FSM:
- IDLE: count to POLL_CYCLES-1, then go to RD_STAT.
- RD_STAT: read 0x17FC. Bit0 = 0 -> IDLE. Bit0 = 1 -> RD_W0.
- RD_W0: read 0x1000. RD_W1: read 0x1004. RD_W3: read 0x100C. RD_W4: read 0x1010. Latch each word.
- CHECK (1 cycle): accept iff all of the following hold:
  - dest = LOCAL_MAC or broadcast;
  - EtherType = ETHERTYPE;
  - command = 0x01;
  - cfg1[15:13] = 0 and cfg2[15:13] = 0;
  - no read returned rresp != 0.
  On accept: update both cfg outputs, pulse cfg_valid, increment rx_good_count. Otherwise increment rx_drop_count. Then CLR.
- CLR: write 32'h0 to 0x17FC with wstrb 4'hF, which releases the buffer to the MAC. bresp is ignored. Then IDLE.
- A read error on the status read itself -> IDLE; no count change.

Read handshake:
- araddr is set and arvalid asserted on state entry; arvalid is held until arready.
- rready is asserted from the arready handshake until rvalid; data is captured on rvalid & rready.
- At most one outstanding read.

Write handshake:
- awvalid and wvalid are asserted together; each drops independently on its own ready.
- bready is asserted after both handshakes complete and drops on bvalid.

Timing and arithmetic:
- Latency from accepting rdata of 0x1010 to cfg_valid: exactly 2 cycles (CHECK, then registered output).
- Counters hold at 16'hFFFF.
- cfg outputs change only together, and only with cfg_valid.
- Poll counter restarts from 0 on every IDLE entry.

Decomposition:
- Shared package eth_lite_pkg holds:
  - address constants RX_PING_BASE = 13'h1000 and RX_PING_CTRL = 13'h17FC (TX constants for the framer live here too);
  - the ETHERTYPE and command code constants;
  - the FSM state enum.
- One natural sub-module: axil_single_master, a one-outstanding read/write engine with start/addr/wdata/done/rdata/err. This FSM sequences it.

Test Plan:
- Status reads 0 on every poll -> reads of 0x17FC spaced POLL_CYCLES+handshake apart; no other addresses issued; outputs stay 0x0EB8/0x0D71.
- Valid frame (dest LOCAL_MAC, type 0x88B5, cmd 0x01, cfg1 0x0C00, cfg2 0x0A00) -> reads 0x17FC, 0x1000, 0x1004, 0x100C, 0x1010; cfg_1_data = 0x0C00 and cfg_2_data = 0x0A00 with a single cfg_valid pulse 2 cycles after last rdata; rx_good_count = 1; write of 0 to 0x17FC.
- Broadcast dest with wrong EtherType 0x0800 -> cfg unchanged; no cfg_valid; rx_drop_count = 1; 0x17FC still cleared.
- cfg1 = 0xE000 (upper bits set) -> frame dropped; rx_drop_count increments; outputs unchanged.
- arready/wready/awready held low 20 cycles and awready granted 5 cycles before wready -> arvalid/awvalid/wvalid stable until their own handshakes; bready is not asserted before both complete; frame still accepted.
- aresetn low during RD_W3 -> next cycle all valids 0 and cfg back to 0x0EB8/0x0D71; after release, polling resumes from IDLE.
